pattern_serializer: RTL and testbench
=====================================

Name: pattern_serializer

Overview:
- Parametrised successor to the counter/decoder/ROM/mux bit-scanner.
- Holds a writable pattern memory of DEPTH words, each WIDTH bits wide.
- On a start request, serialises one word, one bit per clock, in either bit order. Loop mode walks consecutive addresses with wrap-around and no gap between words.
- Sits between a control FSM and a serial output pin; drives valid/busy/done status.

Parameters:
- WIDTH, 8, bits per pattern word (>=2).
- DEPTH, 8, number of pattern words (>=2, power of two).
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden).
- CNT_W, $clog2(WIDTH), bit-index width (derived).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  pattern memory write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- start  in  1  begin serialising; sampled only in IDLE.
- rd_addr  in  ADDR_W  first word address, captured with start.
- msb_first  in  1  bit order, captured with start (0 = LSB first).
- loop  in  1  continue to next address after each word, captured with start.
- stop  in  1  end a loop at the end of the current word.
- out  out  1  serial data bit.
- out_valid  out  1  out holds a pattern bit.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last bit of each word.
- cur_addr  out  ADDR_W  address of the word being shifted.
- bit_idx  out  CNT_W  index of the bit currently on out.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - out, out_valid, busy and done = 0; cur_addr and bit_idx = 0.
  - Memory word i reloads to its thermometer value: the low min(i+1,WIDTH) bits set (WIDTH=8: 01,03,07,0F,1F,3F,7F,FF).
- Memory:
  - Writes are synchronous, at any state.
  - Reads are combinational into the shift register only at a word-load edge.
  - A write to the word currently shifting does not affect the bits in flight; it takes effect at the next load of that address.
  - A write on the same edge as a load of that address: the load takes the old value.
- States:
  - IDLE -> SHIFT: on start=1. At that edge:
    - shift register <= mem[rd_addr]; mode latched; cur_addr <= rd_addr.
    - bit_idx <= 0 if LSB first, WIDTH-1 if MSB first.
    - out <= selected bit; out_valid <= 1; busy <= 1.
    - Latency from the start edge to the first valid bit is 0 cycles (registered at the start edge).
  - SHIFT:
    - Each edge advances bit_idx (+1 LSB first, -1 MSB first) and out follows it.
    - The last bit (idx WIDTH-1 or 0) is held for one cycle; exactly WIDTH valid cycles per word.
  - End of word, on the edge after the last bit:
    - done <= 1 for one cycle.
    - If loop=1 and stop has not been seen: cur_addr <= cur_addr+1, wrapping DEPTH-1 -> 0. The new word loads on the same edge, out_valid stays 1 and the first bit follows with no gap.
    - Otherwise -> IDLE, out_valid <= 0, busy <= 0, out <= 0.
  - stop is sticky: once sampled high in SHIFT it is held until the end of the current word, then forces the IDLE path. stop in IDLE is ignored.
- start in SHIFT is ignored, with no queueing.
- start on the same edge as the return to IDLE is not accepted; start must be sampled while in IDLE.
- Reset mid-word: immediate abort to reset values; no done pulse; memory contents are restored to the thermometer pattern.

Decomposition:
- Shared package: state encoding (IDLE, SHIFT), thermometer init function, and a bit-order constant for LSB_FIRST.
- One sub-module, pattern_mem:
  - DEPTH x WIDTH storage with async reset-to-thermometer, sync write, combinational read.
- Serialiser FSM, bit counter and address counter stay in the top.

Test Plan:
- Reset, then start, rd_addr=3, msb_first=0, loop=0 -> out = 1,1,1,1,0,0,0,0 over 8 cycles. out_valid high for exactly 8 cycles; done pulses once on cycle 9; busy then drops.
- Write mem[5]=8'hA5, then start rd_addr=5, msb_first=1 -> out = 1,0,1,0,0,1,0,1; bit_idx 7 down to 0.
- loop=1, rd_addr=6, stop asserted during the second word -> words 7F then FF then end. cur_addr goes 6,7 and wraps to 0 only if stop is late. With stop in word 2: exactly 16 contiguous valid bits and 2 done pulses.
- Loop from rd_addr=7 -> cur_addr wraps 7 -> 0; first bit of word 0 (=1) appears on the cycle after done with no gap.
- During serialisation of addr 2, write mem[2]=8'h00 and assert start -> current output stays 1,1,1,0,0,0,0,0; start is ignored. A later start at addr 2 outputs all zeros.
- Reset pulled low at bit 4 -> out, out_valid, busy and done are 0 immediately. mem[2] reads 8'h07 again after reset release.

Source files
------------

// File: rtl/pattern_serializer_pkg.sv
// Shared types and helpers for the pattern serialiser: FSM state encoding,
// bit-order constant and the reset-time thermometer pattern generator.
package pattern_serializer_pkg;

  // Serialiser FSM states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Value of msb_first that selects LSB-first shifting.
  localparam logic LSB_FIRST = 1'b0;

  // Widest pattern word the thermometer helper can produce.
  localparam int THERM_MAX_W = 64;

  // Reset value of pattern word idx: the low min(idx+1, width) bits set.
  // Callers truncate the result to their own word width.
  function automatic logic [THERM_MAX_W-1:0] therm_word(input int idx, input int width);
    logic [THERM_MAX_W-1:0] w;
    w = '0;
    for (int b = 0; b < THERM_MAX_W; b++) begin
      w[b] = (b < width) && (b <= idx);
    end
    return w;
  endfunction

endpackage

// File: rtl/pattern_serializer_if.sv
// Control/status bundle between the control FSM (master) and the serialiser
// (slave): pattern writes, start/stop control and serial output status.
interface pattern_serializer_if
  import pattern_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(WIDTH);

  // Pattern memory write port.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  // Serialisation control.
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic              msb_first;
  logic              loop;
  logic              stop;

  // Serial output and status.
  logic              out;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  bit_idx;

  modport master (
    output wr_en, wr_addr, wr_data, start, rd_addr, msb_first, loop, stop,
    input  out, out_valid, busy, done, cur_addr, bit_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, rd_addr, msb_first, loop, stop,
    output out, out_valid, busy, done, cur_addr, bit_idx
  );

endinterface

// File: rtl/pattern_mem.sv
// DEPTH x WIDTH pattern storage: asynchronous reset to the thermometer
// pattern, synchronous write, combinational read.
module pattern_mem
  import pattern_serializer_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Reset every word to its thermometer value; otherwise apply writes.
  // NOTE: this is a flop array, not an SRAM macro, so it can (and must) take
  // the async reset. Non-blocking writes mean a load on the same edge as a
  // write to that word still sees the old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(therm_word(i, WIDTH));
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pattern_serializer.sv
// Pattern serialiser top: shifts one stored word per start request out of a
// single pin, one bit per clock, LSB or MSB first, optionally looping over
// consecutive addresses with no gap until stopped.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               reset,
  pattern_serializer_if.slave bus
);

  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(WIDTH - 1);

  // FSM state and latched mode.
  state_t            state_q;
  logic [WIDTH-1:0]  sreg_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [CNT_W-1:0]  bit_idx_q;
  logic              msb_first_q;
  logic              loop_q;
  logic              stop_q;

  // Registered outputs.
  logic              out_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;

  // Word-load and bit-step helpers.
  logic              load_msb;
  logic [ADDR_W-1:0] load_addr;
  logic [WIDTH-1:0]  load_word;
  logic [CNT_W-1:0]  load_idx;
  logic [CNT_W-1:0]  last_idx;
  logic [CNT_W-1:0]  step_idx;
  logic              word_end;
  logic              stop_seen;

  pattern_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_addr_i (load_addr),
    .rd_data_o (load_word)
  );

  // Select the word to load (start address from IDLE, next address when
  // looping) and derive the first/last/next bit index for the bit order.
  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    load_msb  = (state_q == ST_IDLE) ? bus.msb_first : msb_first_q;
    load_addr = (state_q == ST_IDLE) ? bus.rd_addr : cur_addr_q + ADDR_W'(1);
    load_idx  = (load_msb == LSB_FIRST) ? '0 : IDX_TOP;
    last_idx  = (msb_first_q == LSB_FIRST) ? IDX_TOP : '0;
    step_idx  = (msb_first_q == LSB_FIRST) ? bit_idx_q + CNT_W'(1)
                                           : bit_idx_q - CNT_W'(1);
    word_end  = (bit_idx_q == last_idx);
    stop_seen = stop_q | bus.stop;
  end

  // Serialiser FSM with bit and address counters; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      cur_addr_q  <= '0;
      bit_idx_q   <= '0;
      msb_first_q <= 1'b0;
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // stop is ignored here; start latches the whole mode.
          if (bus.start) begin
            state_q     <= ST_SHIFT;
            sreg_q      <= load_word;
            cur_addr_q  <= load_addr;
            bit_idx_q   <= load_idx;
            msb_first_q <= bus.msb_first;
            loop_q      <= bus.loop;
            stop_q      <= 1'b0;
            out_q       <= load_word[load_idx];
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (word_end) begin
            // Edge after the last bit: pulse done, then chain or finish.
            done_q <= 1'b1;
            stop_q <= 1'b0;
            if (loop_q && !stop_seen) begin
              sreg_q     <= load_word;
              cur_addr_q <= load_addr;
              bit_idx_q  <= load_idx;
              out_q      <= load_word[load_idx];
            end else begin
              state_q     <= ST_IDLE;
              out_q       <= 1'b0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
            end
          end else begin
            // Mid-word: step to the next bit and remember any stop request.
            stop_q    <= stop_seen;
            bit_idx_q <= step_idx;
            out_q     <= sreg_q[step_idx];
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cur_addr  = cur_addr_q;
  assign bus.bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: directed scenarios plus
// randomized runs, each compared cycle by cycle against a stream model.
`timescale 1ns/1ps
module tb_pattern_serializer;

  localparam int W    = 8;
  localparam int D    = 8;
  localparam int AW   = $clog2(D);
  localparam int CW   = $clog2(W);
  localparam int MAXC = 64;

  typedef struct packed {
    logic          busy;
    logic          valid;
    logic          out;
    logic          done;
    logic [AW-1:0] addr;
    logic [CW-1:0] idx;
  } sample_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pattern_serializer_if #(.WIDTH(W), .DEPTH(D)) bus ();
  pattern_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int       n_checks = 0;
  int       n_errors = 0;
  logic [W-1:0] model_mem [D];
  sample_t  obs   [MAXC];
  sample_t  exp_s [MAXC];

  // Model memory after reset: word i has its low min(i+1, W) bits set.
  function automatic void model_reset();
    for (int i = 0; i < D; i++) begin
      int n;
      n = (i + 1 < W) ? i + 1 : W;
      model_mem[i] = W'((1 << n) - 1);
    end
  endfunction

  // Observed outputs; address/index only meaningful while valid.
  function automatic sample_t sample_dut(input bit mask);
    sample_t s;
    s.busy  = bus.busy;
    s.valid = bus.out_valid;
    s.out   = bus.out;
    s.done  = bus.done;
    s.addr  = (mask && !bus.out_valid) ? '0 : bus.cur_addr;
    s.idx   = (mask && !bus.out_valid) ? '0 : bus.bit_idx;
    return s;
  endfunction

  // Expected stream: cycle 0 is the cycle after the start edge. Each word
  // takes W cycles; a stop during any cycle of a word ends the loop after it.
  function automatic void build_expected(input int a, input bit msb, input bit lp,
                                         input int stop_cyc, input int ncyc);
    int nwords;
    nwords = (lp && stop_cyc >= 0) ? stop_cyc / W + 1 : (lp ? MAXC : 1);
    for (int c = 0; c < ncyc; c++) begin
      exp_s[c] = '0;
      if (c < nwords * W) begin
        int w, j, ad, ix;
        w  = c / W;
        j  = c % W;
        ad = (a + w) % D;
        ix = msb ? W - 1 - j : j;
        exp_s[c].busy  = 1'b1;
        exp_s[c].valid = 1'b1;
        exp_s[c].out   = model_mem[ad][ix];
        exp_s[c].done  = (c > 0) && (j == 0);
        exp_s[c].addr  = AW'(ad);
        exp_s[c].idx   = CW'(ix);
      end else if (c == nwords * W) begin
        exp_s[c].done = 1'b1;
      end
    end
  endfunction

  task automatic write_word(input int a, input logic [W-1:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Start a word and record ncyc cycles. pre_stop drives stop while still
  // idle; wr_cyc = -1 writes on the start edge itself.
  task automatic run_capture(input int a, input bit msb, input bit lp, input bit pre_stop,
                             input int stop_cyc, input int start_cyc, input int wr_cyc,
                             input int wr_a, input logic [W-1:0] wr_d, input int ncyc);
    @(negedge clk);
    bus.start = 1'b1; bus.rd_addr = AW'(a); bus.msb_first = msb; bus.loop = lp;
    bus.stop = pre_stop;
    bus.wr_en = (wr_cyc == -1); bus.wr_addr = AW'(wr_a); bus.wr_data = wr_d;
    @(posedge clk); #1;
    bus.rd_addr = AW'($urandom_range(D - 1));
    bus.msb_first = 1'($urandom_range(1));
    bus.loop = 1'($urandom_range(1));
    for (int c = 0; c < ncyc; c++) begin
      bus.stop  = (c == stop_cyc);
      bus.start = (c == start_cyc);
      bus.wr_en = (c == wr_cyc);
      @(negedge clk);
      obs[c] = sample_dut(1'b1);
      @(posedge clk); #1;
    end
    bus.stop = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (sample_dut(1'b0) !== '0) begin
      n_errors++;
      $display("FAIL reset_values: got %h, expected %h", sample_dut(1'b0), sample_t'('0));
    end
    model_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (sample_dut(1'b0) !== '0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got %h, expected %h", sample_dut(1'b0), sample_t'('0));
    end
  endtask

  task automatic test_lsb_single();
    build_expected(3, 1'b0, 1'b0, -1, W + 3);
    run_capture(3, 1'b0, 1'b0, 1'b0, -1, -1, -2, 0, '0, W + 3);
    for (int c = 0; c < W + 3; c++) begin
      n_checks++;
      if (obs[c] !== exp_s[c]) begin
        n_errors++;
        $display("FAIL lsb_single cycle %0d: got %h, expected %h", c, obs[c], exp_s[c]);
      end
    end
  endtask

  // A5 MSB first; a start on the final-bit cycle must not be accepted.
  task automatic test_msb_written();
    write_word(5, 8'hA5);
    build_expected(5, 1'b1, 1'b0, -1, W + 4);
    run_capture(5, 1'b1, 1'b0, 1'b0, -1, W - 1, -2, 0, '0, W + 4);
    for (int c = 0; c < W + 4; c++) begin
      n_checks++;
      if (obs[c] !== exp_s[c]) begin
        n_errors++;
        $display("FAIL msb_written cycle %0d: got %h, expected %h", c, obs[c], exp_s[c]);
      end
    end
  endtask

  task automatic test_loop_stop();
    build_expected(6, 1'b0, 1'b1, W + 3, 2 * W + 3);
    run_capture(6, 1'b0, 1'b1, 1'b0, W + 3, -1, -2, 0, '0, 2 * W + 3);
    for (int c = 0; c < 2 * W + 3; c++) begin
      n_checks++;
      if (obs[c] !== exp_s[c]) begin
        n_errors++;
        $display("FAIL loop_stop cycle %0d: got %h, expected %h", c, obs[c], exp_s[c]);
      end
    end
  endtask

  // Wrap 7 -> 0; a stop held while idle must be ignored.
  task automatic test_loop_wrap();
    build_expected(7, 1'b1, 1'b1, W + 1, 2 * W + 3);
    run_capture(7, 1'b1, 1'b1, 1'b1, W + 1, -1, -2, 0, '0, 2 * W + 3);
    for (int c = 0; c < 2 * W + 3; c++) begin
      n_checks++;
      if (obs[c] !== exp_s[c]) begin
        n_errors++;
        $display("FAIL loop_wrap cycle %0d: got %h, expected %h", c, obs[c], exp_s[c]);
      end
    end
  endtask

  // Write to the word on its own load edge plus a mid-word start: neither
  // may disturb the bits in flight; the next load sees the new value.
  task automatic test_write_inflight();
    build_expected(2, 1'b0, 1'b0, -1, W + 2);
    run_capture(2, 1'b0, 1'b0, 1'b0, -1, 3, -1, 2, 8'h00, W + 2);
    model_mem[2] = 8'h00;
    for (int c = 0; c < W + 2; c++) begin
      n_checks++;
      if (obs[c] !== exp_s[c]) begin
        n_errors++;
        $display("FAIL write_inflight cycle %0d: got %h, expected %h", c, obs[c], exp_s[c]);
      end
    end
    build_expected(2, 1'b0, 1'b0, -1, W + 1);
    run_capture(2, 1'b0, 1'b0, 1'b0, -1, -1, -2, 0, '0, W + 1);
    for (int c = 0; c < W + 1; c++) begin
      n_checks++;
      if (obs[c] !== exp_s[c]) begin
        n_errors++;
        $display("FAIL write_reload cycle %0d: got %h, expected %h", c, obs[c], exp_s[c]);
      end
    end
  endtask

  task automatic test_reset_midword();
    @(negedge clk);
    bus.start = 1'b1; bus.rd_addr = AW'(2); bus.msb_first = 1'b0; bus.loop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.bit_idx !== CW'(4)) begin
      n_errors++;
      $display("FAIL midword_pos: got valid=%b idx=%0d, expected valid=1 idx=4",
               bus.out_valid, bus.bit_idx);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (sample_dut(1'b0) !== '0) begin
      n_errors++;
      $display("FAIL midword_reset: got %h, expected %h", sample_dut(1'b0), sample_t'('0));
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    n_checks++;
    if (sample_dut(1'b0) !== '0) begin
      n_errors++;
      $display("FAIL no_done_after_reset: got %h, expected %h", sample_dut(1'b0), sample_t'('0));
    end
    build_expected(2, 1'b0, 1'b0, -1, W + 1);
    run_capture(2, 1'b0, 1'b0, 1'b0, -1, -1, -2, 0, '0, W + 1);
    for (int c = 0; c < W + 1; c++) begin
      n_checks++;
      if (obs[c] !== exp_s[c]) begin
        n_errors++;
        $display("FAIL mem_restored cycle %0d: got %h, expected %h", c, obs[c], exp_s[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) write_word($urandom_range(D - 1), W'($urandom));
    for (int it = 0; it < 20; it++) begin
      int a, stop_cyc, start_cyc, wr_cyc, nwords, ncyc;
      bit msb, lp, pre;
      logic [W-1:0] wd;
      a        = $urandom_range(D - 1);
      msb      = 1'($urandom_range(1));
      lp       = 1'($urandom_range(1));
      pre      = 1'($urandom_range(1));
      stop_cyc = $urandom_range(2 * W - 1);
      nwords   = lp ? stop_cyc / W + 1 : 1;
      start_cyc = $urandom_range(nwords * W - 1);
      wr_cyc   = $urandom_range(W) - 1;
      wd       = W'($urandom);
      ncyc     = 2 * W + 3;
      build_expected(a, msb, lp, stop_cyc, ncyc);
      run_capture(a, msb, lp, pre, stop_cyc, start_cyc, wr_cyc, a, wd, ncyc);
      model_mem[a] = wd;
      for (int c = 0; c < ncyc; c++) begin
        n_checks++;
        if (obs[c] !== exp_s[c]) begin
          n_errors++;
          $display("FAIL random it%0d cycle %0d: got %h, expected %h", it, c, obs[c], exp_s[c]);
        end
      end
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.rd_addr = '0; bus.msb_first = 1'b0;
    bus.loop = 1'b0; bus.stop = 1'b0;
    test_reset();
    test_lsb_single();
    test_msb_written();
    test_loop_stop();
    test_loop_wrap();
    test_write_inflight();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
